cmd_phy_scheduler: RTL and testbench
====================================

// Module: cmd_phy_scheduler
// PURPOSE
// Shares the command physical layer (capa_fisica) between two requesters: req0 = host register
// path, req1 = data-path auto command (e.g. CMD12). Arbitrates, drives the phy strobe/ack handshake,
// retries timed-out commands and guards against a hung phy with a watchdog. Returns one response
// record per accepted command. Sits between the command-layer logic and capa_fisica.
// PARAMETERS
// CMD_W      40    command frame width, matches phy cmd_to_send
// RESP_W     128   response width, matches phy response
// MAX_RETRY  2     extra send attempts after a phy command_timeout (0 = no retry)
// WDOG_CYC   4096  max cycles in SEND+WAIT_RESP before abort; >= 2
// PORTS
// sd_clock           in   1       single clock; all logic on rising edge
// reset              in   1       asynchronous, active-high
// req0_valid         in   1       req0 has a command; hold until req0_ready
// req0_cmd           in   CMD_W   req0 command frame
// req0_no_resp       in   1       req0 command expects no response
// req0_ready         out  1       req0 command accepted this cycle
// req1_valid/req1_cmd/req1_no_resp/req1_ready    same for req1
// rsp_valid          out  1       response record valid; held until rsp_ready
// rsp_id             out  1       requester that issued the command
// rsp_data           out  RESP_W  latched phy response
// rsp_timeout        out  1       command timed out after all retries
// rsp_abort          out  1       watchdog abort; rsp_data = 0
// rsp_ready          in   1       consumer takes response
// busy               out  1       state != IDLE
// phy_strobe_in      out  1       to phy strobe_in: command present
// phy_cmd            out  CMD_W   to phy cmd_to_send, registered
// phy_no_response    out  1       to phy no_response
// phy_idle_in        out  1       to phy idle_in
// phy_ack_in         out  1       to phy ack_in: response consumed
// phy_ack_out        in   1       phy accepted command
// phy_strobe_out     in   1       phy result ready (response or timeout)
// phy_response       in   RESP_W  phy response
// phy_command_timeout in  1       phy result is a timeout
// BEHAVIOUR
// Reset: state=IDLE, all outputs 0 except phy_idle_in=1; last_grant=1; retry_cnt=0; wdog=0.
// States: IDLE, GRANT, SEND, WAIT_RESP, ACK, ABORT, DONE.
// IDLE: phy_idle_in=1. If any reqX_valid -> GRANT; winner chosen here, registered as sel.
// Arbitration: round-robin; both valid -> grant the one != last_grant; single valid -> that one.
//   last_grant <= sel on GRANT. After reset req0 wins the first tie.
// GRANT (1 cycle): req<sel>_ready=1 (combinational from state, sel); phy_cmd/phy_no_response/
//   rsp_id latched from req<sel>; retry_cnt=0, wdog=0 -> SEND. Unselected requester waits.
// SEND: phy_strobe_in=1 until phy_ack_out sampled 1 -> WAIT_RESP (strobe drops next cycle).
// WAIT_RESP: phy_strobe_in=0. On phy_strobe_out=1: latch phy_response, phy_command_timeout -> ACK.
// ACK: phy_ack_in=1 while phy_strobe_out=1; on phy_strobe_out=0:
//   timeout && !no_resp && retry_cnt<MAX_RETRY -> retry_cnt++, wdog=0, SEND (same phy_cmd);
//   else -> DONE with rsp_timeout=latched timeout && !no_resp.
// no_resp commands: timeout flag ignored, never retried, rsp_data as returned by phy.
// Watchdog: wdog counts every cycle in SEND/WAIT_RESP, saturating; wdog==WDOG_CYC-1 while
//   still in SEND/WAIT_RESP -> ABORT (takes precedence over same-cycle phy_ack_out/strobe_out).
// ABORT (2 cycles): phy_idle_in=1, phy_strobe_in=0, phy_ack_in=0 to re-idle phy -> DONE with
//   rsp_abort=1, rsp_timeout=0, rsp_data=0.
// DONE: rsp_valid=1, fields stable; rsp_ready=1 -> IDLE and clear rsp_valid next cycle. No new
//   grant until DONE exits (one command in flight; rsp_ready=1 in IDLE is ignored).
// Min latency, no retry: GRANT at N+1 after valid at N, phy_strobe_in high at N+2.
// reqX_valid dropped before ready: no command issued, no response. reset mid-op: immediate return
//   to reset values; partial response discarded.
// TESTING
// req0_valid, cmd=40'h40_0000_0000, phy acks 3 cyc later, strobe_out with resp=128'hA5 -> 1 ready pulse, rsp_id=0, rsp_data=A5, timeout=0
// req0+req1 valid same cycle after reset, twice -> grant order 0,1,0,1 (req1 stays valid)
// phy_command_timeout=1 on 3 results, MAX_RETRY=2 -> 3 strobes on phy_strobe_in, rsp_timeout=1
// timeout on 1st try, OK on 2nd -> 2 sends, rsp_timeout=0, rsp_data from 2nd result
// phy never asserts ack_out, WDOG_CYC=16 -> ABORT at cycle 16 of SEND, phy_idle_in 2 cyc, rsp_abort=1
// reset asserted in WAIT_RESP -> all outputs reset at once, phy_idle_in=1, no rsp_valid after release

Source files
------------

// File: rtl/cmd_phy_scheduler.sv
// cmd_phy_scheduler
//   Shares the command phy between two requesters (req0 = host register path,
//   req1 = data-path auto command). Round-robin arbitration, one command in
//   flight, phy strobe/ack handshake, retry on phy timeout, and a watchdog that
//   aborts and re-idles a hung phy. One response record per accepted command.
// Ports
//   sd_clock, reset          clock, asynchronous active-high reset
//   reqN_valid/cmd/no_resp   command request from requester N (held until ready)
//   reqN_ready               command accepted this cycle
//   rsp_valid/id/data        response record, held until rsp_ready
//   rsp_timeout, rsp_abort   result flags (timeout after all retries / watchdog)
//   busy                     scheduler not idle
//   phy_*                    handshake with the command phy
module cmd_phy_scheduler #(
   parameter int CMD_W     = 40,
   parameter int RESP_W    = 128,
   parameter int MAX_RETRY = 2,
   parameter int WDOG_CYC  = 4096
) (
   input  logic              sd_clock,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [CMD_W-1:0]  req0_cmd,
   input  logic              req0_no_resp,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [CMD_W-1:0]  req1_cmd,
   input  logic              req1_no_resp,
   output logic              req1_ready,
   output logic              rsp_valid,
   output logic              rsp_id,
   output logic [RESP_W-1:0] rsp_data,
   output logic              rsp_timeout,
   output logic              rsp_abort,
   input  logic              rsp_ready,
   output logic              busy,
   output logic              phy_strobe_in,
   output logic [CMD_W-1:0]  phy_cmd,
   output logic              phy_no_response,
   output logic              phy_idle_in,
   output logic              phy_ack_in,
   input  logic              phy_ack_out,
   input  logic              phy_strobe_out,
   input  logic [RESP_W-1:0] phy_response,
   input  logic              phy_command_timeout
);

   typedef enum logic [2:0] {IDLE, GRANT, SEND, WAIT_RESP, ACK, ABORT, DONE} state_t;

   localparam int RW = $clog2(MAX_RETRY + 2);
   localparam int WW = $clog2(WDOG_CYC);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
   localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYC - 1);

   state_t        state;
   logic          sel;
   logic          last_grant;
   logic          lat_timeout;
   logic          abort_cnt;
   logic [RW-1:0] retry_cnt;
   logic [WW-1:0] wdog;

   logic pick, sel_valid, wdog_hit, retry;

   // Tie goes to the requester that was not granted last; otherwise the lone requester.
   assign pick      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
   assign sel_valid = sel ? req1_valid : req0_valid;

   // Ready is gated by valid: a requester that withdrew during GRANT is not accepted.
   assign req0_ready = (state == GRANT) && !sel && req0_valid;
   assign req1_ready = (state == GRANT) &&  sel && req1_valid;

   assign wdog_hit = (wdog == WDOG_LAST);
   // no-response commands never retry, their timeout flag is meaningless
   assign retry    = lat_timeout && !phy_no_response && (retry_cnt < RETRY_MAX);

   always_ff @(posedge sd_clock or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         sel             <= 1'b0;
         last_grant      <= 1'b1;
         lat_timeout     <= 1'b0;
         abort_cnt       <= 1'b0;
         retry_cnt       <= '0;
         wdog            <= '0;
         rsp_valid       <= 1'b0;
         rsp_id          <= 1'b0;
         rsp_data        <= '0;
         rsp_timeout     <= 1'b0;
         rsp_abort       <= 1'b0;
         busy            <= 1'b0;
         phy_strobe_in   <= 1'b0;
         phy_cmd         <= '0;
         phy_no_response <= 1'b0;
         phy_idle_in     <= 1'b1;
         phy_ack_in      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0_valid || req1_valid) begin
                  sel         <= pick;
                  busy        <= 1'b1;
                  phy_idle_in <= 1'b0;
                  state       <= GRANT;
               end
            end

            GRANT: begin
               last_grant <= sel;
               if (sel_valid) begin
                  phy_cmd         <= sel ? req1_cmd : req0_cmd;
                  phy_no_response <= sel ? req1_no_resp : req0_no_resp;
                  rsp_id          <= sel;
                  retry_cnt       <= '0;
                  wdog            <= '0;
                  phy_strobe_in   <= 1'b1;
                  state           <= SEND;
               end else begin
                  // request withdrawn before acceptance: nothing issued
                  busy        <= 1'b0;
                  phy_idle_in <= 1'b1;
                  state       <= IDLE;
               end
            end

            SEND: begin
               // watchdog wins over a same-cycle ack; it never passes WDOG_LAST
               if (wdog_hit) begin
                  abort_cnt     <= 1'b0;
                  phy_strobe_in <= 1'b0;
                  phy_ack_in    <= 1'b0;
                  phy_idle_in   <= 1'b1;
                  state         <= ABORT;
               end else begin
                  wdog <= wdog + 1'b1;
                  if (phy_ack_out) begin
                     phy_strobe_in <= 1'b0;
                     state         <= WAIT_RESP;
                  end
               end
            end

            WAIT_RESP: begin
               if (wdog_hit) begin
                  abort_cnt     <= 1'b0;
                  phy_strobe_in <= 1'b0;
                  phy_ack_in    <= 1'b0;
                  phy_idle_in   <= 1'b1;
                  state         <= ABORT;
               end else begin
                  wdog <= wdog + 1'b1;
                  if (phy_strobe_out) begin
                     rsp_data    <= phy_response;
                     lat_timeout <= phy_command_timeout;
                     phy_ack_in  <= 1'b1;
                     state       <= ACK;
                  end
               end
            end

            ACK: begin
               // hold ack until the phy withdraws its result
               if (!phy_strobe_out) begin
                  phy_ack_in <= 1'b0;
                  if (retry) begin
                     retry_cnt     <= retry_cnt + 1'b1;
                     wdog          <= '0;
                     phy_strobe_in <= 1'b1;
                     state         <= SEND;
                  end else begin
                     rsp_timeout <= lat_timeout && !phy_no_response;
                     rsp_abort   <= 1'b0;
                     rsp_valid   <= 1'b1;
                     state       <= DONE;
                  end
               end
            end

            ABORT: begin
               // two cycles of idle_in with strobe/ack low to re-idle the phy
               if (abort_cnt) begin
                  phy_idle_in <= 1'b0;
                  rsp_abort   <= 1'b1;
                  rsp_timeout <= 1'b0;
                  rsp_data    <= '0;
                  rsp_valid   <= 1'b1;
                  state       <= DONE;
               end else begin
                  abort_cnt <= 1'b1;
               end
            end

            DONE: begin
               if (rsp_ready) begin
                  rsp_valid   <= 1'b0;
                  busy        <= 1'b0;
                  phy_idle_in <= 1'b1;
                  state       <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_phy_scheduler.sv
// Bench for cmd_phy_scheduler: directed requests, a behavioural phy that plays
// back a queue of results, and a scoreboard monitor that checks every response.
module tb_cmd_phy_scheduler;
   localparam int CMD_W     = 40;
   localparam int RESP_W    = 128;
   localparam int MAX_RETRY = 2;
   localparam int WDOG_CYC  = 16;

   logic              sd_clock = 1'b0;
   logic              reset    = 1'b1;
   logic              req0_valid = 1'b0, req1_valid = 1'b0;
   logic [CMD_W-1:0]  req0_cmd = '0, req1_cmd = '0;
   logic              req0_no_resp = 1'b0, req1_no_resp = 1'b0;
   logic              req0_ready, req1_ready;
   logic              rsp_valid, rsp_id, rsp_timeout, rsp_abort;
   logic [RESP_W-1:0] rsp_data;
   logic              rsp_ready = 1'b1;
   logic              busy, phy_strobe_in, phy_no_response, phy_idle_in, phy_ack_in;
   logic [CMD_W-1:0]  phy_cmd;
   logic              phy_ack_out, phy_strobe_out, phy_command_timeout;
   logic [RESP_W-1:0] phy_response;

   cmd_phy_scheduler #(.CMD_W(CMD_W), .RESP_W(RESP_W), .MAX_RETRY(MAX_RETRY), .WDOG_CYC(WDOG_CYC)) dut (
      .sd_clock(sd_clock), .reset(reset),
      .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_no_resp(req0_no_resp), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_no_resp(req1_no_resp), .req1_ready(req1_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
      .rsp_abort(rsp_abort), .rsp_ready(rsp_ready), .busy(busy),
      .phy_strobe_in(phy_strobe_in), .phy_cmd(phy_cmd), .phy_no_response(phy_no_response),
      .phy_idle_in(phy_idle_in), .phy_ack_in(phy_ack_in), .phy_ack_out(phy_ack_out),
      .phy_strobe_out(phy_strobe_out), .phy_response(phy_response),
      .phy_command_timeout(phy_command_timeout)
   );

   always #5 sd_clock = ~sd_clock;

   typedef struct {
      logic              id;
      logic [RESP_W-1:0] data;
      logic              timeout;
      logic              abort;
   } exp_t;
   typedef struct {
      logic              timeout;
      logic [RESP_W-1:0] resp;
   } res_t;

   exp_t exp_q[$];
   res_t res_q[$];
   int   grant_log[$];

   int n_vec = 0, n_err = 0;
   int cyc = 0, valid_cyc = 0, strobe_cyc = 0;
   int ack_delay = 3, resp_delay = 2, n_strobe = 0, ready0_cnt = 0;
   bit never_ack = 1'b0;
   logic [CMD_W-1:0] seen_cmd = '0;
   logic seen_nr = 1'b0;

   task automatic check(input string name, input logic [RESP_W-1:0] act, input logic [RESP_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk_exp(input logic id, input logic [RESP_W-1:0] d, input logic t, input logic a);
      exp_t e;
      e.id = id; e.data = d; e.timeout = t; e.abort = a;
      return e;
   endfunction

   function automatic res_t mk_res(input logic t, input logic [RESP_W-1:0] r);
      res_t x;
      x.timeout = t; x.resp = r;
      return x;
   endfunction

   initial forever begin
      @(posedge sd_clock);
      cyc++;
   end

   // scoreboard monitor: compares on every response handshake
   initial begin
      exp_t e;
      forever begin
         @(negedge sd_clock);
         if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_rsp: got id=%0d data=%0h, expected no response", rsp_id, rsp_data);
            end else begin
               e = exp_q.pop_front();
               check("rsp_id", rsp_id, e.id);
               check("rsp_data", rsp_data, e.data);
               check("rsp_timeout", rsp_timeout, e.timeout);
               check("rsp_abort", rsp_abort, e.abort);
            end
         end
         if (!reset && req0_ready) begin grant_log.push_back(0); ready0_cnt++; end
         if (!reset && req1_ready) grant_log.push_back(1);
      end
   end

   // behavioural phy
   initial begin
      int pst, cnt;
      res_t r;
      pst = 0; cnt = 0;
      phy_ack_out = 1'b0; phy_strobe_out = 1'b0; phy_response = '0; phy_command_timeout = 1'b0;
      forever begin
         @(posedge sd_clock); #1;
         if (reset) begin
            pst = 0;
            phy_ack_out = 1'b0; phy_strobe_out = 1'b0; phy_command_timeout = 1'b0;
         end else begin
            case (pst)
               0: if (phy_strobe_in) begin
                     n_strobe++; seen_cmd = phy_cmd; seen_nr = phy_no_response; strobe_cyc = cyc;
                     cnt = ack_delay; pst = 1;
                  end
               1: if (never_ack) begin
                     if (phy_idle_in) pst = 0;
                  end else if (cnt == 0) begin
                     phy_ack_out = 1'b1; pst = 2;
                  end else cnt--;
               2: begin phy_ack_out = 1'b0; cnt = resp_delay; pst = 3; end
               3: if (cnt == 0) begin
                     r = (res_q.size() > 0) ? res_q.pop_front() : mk_res(1'b0, '0);
                     phy_response = r.resp; phy_command_timeout = r.timeout; phy_strobe_out = 1'b1;
                     pst = 4;
                  end else cnt--;
               default: if (phy_ack_in) begin
                     phy_strobe_out = 1'b0; phy_command_timeout = 1'b0; pst = 0;
                  end
            endcase
         end
      end
   end

   // caller is aligned to posedge+1
   task automatic send_req(input int id, input logic [CMD_W-1:0] cmd, input logic nr);
      bit got = 1'b0;
      if (id == 0) begin req0_cmd = cmd; req0_no_resp = nr; req0_valid = 1'b1; end
      else         begin req1_cmd = cmd; req1_no_resp = nr; req1_valid = 1'b1; end
      valid_cyc = cyc;
      for (int i = 0; i < 300; i++) begin
         @(negedge sd_clock);
         if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin got = 1'b1; break; end
      end
      @(posedge sd_clock); #1;
      if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      if (!got) begin
         n_vec++; n_err++;
         $display("FAIL req%0d_accept: no ready within 300 cycles, expected acceptance", id);
      end
   endtask

   task automatic wait_drain(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge sd_clock);
         if (exp_q.size() == 0 && !busy) begin ok = 1'b1; break; end
      end
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s_drain: %0d responses outstanding busy=%0d, expected 0 and idle", name, exp_q.size(), busy);
      end
      @(posedge sd_clock); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge sd_clock);
      #1 reset = 1'b0;
   endtask

   initial begin
      int lat, hi, vcount;
      int exp_order[4] = '{0, 1, 0, 1};

      // reset state
      repeat (3) @(posedge sd_clock);
      @(negedge sd_clock);
      check("rst_busy", busy, 0);
      check("rst_idle_in", phy_idle_in, 1);
      check("rst_strobe_in", phy_strobe_in, 0);
      check("rst_ack_in", phy_ack_in, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_phy_cmd", phy_cmd, 0);
      check("rst_readies", {req0_ready, req1_ready}, 0);
      @(posedge sd_clock); #1 reset = 1'b0;
      @(posedge sd_clock); #1;

      // basic command, response held while consumer stalls
      res_q.push_back(mk_res(1'b0, 128'hA5));
      exp_q.push_back(mk_exp(1'b0, 128'hA5, 1'b0, 1'b0));
      rsp_ready = 1'b0; ready0_cnt = 0; n_strobe = 0;
      send_req(0, 40'h40_0000_0000, 1'b0);
      check("min_latency", strobe_cyc - valid_cyc, 2);
      lat = 0;
      while (!rsp_valid && lat < 100) begin @(negedge sd_clock); lat++; end
      repeat (3) @(negedge sd_clock);
      check("rsp_hold_valid", rsp_valid, 1);
      check("rsp_hold_data", rsp_data, 128'hA5);
      @(posedge sd_clock); #1 rsp_ready = 1'b1;
      wait_drain("basic");
      check("ready0_pulses", ready0_cnt, 1);
      check("phy_cmd", seen_cmd, 40'h40_0000_0000);
      check("basic_strobes", n_strobe, 1);

      // round robin: both valid after reset, twice
      do_reset();
      @(posedge sd_clock); #1;
      grant_log.delete();
      res_q.push_back(mk_res(1'b0, 128'h11)); res_q.push_back(mk_res(1'b0, 128'h22));
      exp_q.push_back(mk_exp(1'b0, 128'h11, 1'b0, 1'b0));
      exp_q.push_back(mk_exp(1'b1, 128'h22, 1'b0, 1'b0));
      fork
         send_req(0, 40'h01, 1'b0);
         send_req(1, 40'h02, 1'b0);
      join
      wait_drain("rr1");
      res_q.push_back(mk_res(1'b0, 128'h33)); res_q.push_back(mk_res(1'b0, 128'h44));
      exp_q.push_back(mk_exp(1'b0, 128'h33, 1'b0, 1'b0));
      exp_q.push_back(mk_exp(1'b1, 128'h44, 1'b0, 1'b0));
      fork
         send_req(0, 40'h03, 1'b0);
         send_req(1, 40'h04, 1'b0);
      join
      wait_drain("rr2");
      check("grant_count", grant_log.size(), 4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++)
         check("grant_order", grant_log[i], exp_order[i]);

      // timeout on every try: 1 + MAX_RETRY sends, last data reported
      res_q.push_back(mk_res(1'b1, 128'h1)); res_q.push_back(mk_res(1'b1, 128'h2));
      res_q.push_back(mk_res(1'b1, 128'h3));
      exp_q.push_back(mk_exp(1'b0, 128'h3, 1'b1, 1'b0));
      n_strobe = 0;
      send_req(0, 40'h0C, 1'b0);
      wait_drain("retry_all");
      check("retry_all_strobes", n_strobe, 3);

      // timeout then success
      res_q.push_back(mk_res(1'b1, 128'h77)); res_q.push_back(mk_res(1'b0, 128'hBEEF));
      exp_q.push_back(mk_exp(1'b1, 128'hBEEF, 1'b0, 1'b0));
      n_strobe = 0;
      send_req(1, 40'h0D, 1'b0);
      wait_drain("retry_ok");
      check("retry_ok_strobes", n_strobe, 2);

      // no-response command: timeout ignored, not retried
      res_q.push_back(mk_res(1'b1, 128'h5A));
      exp_q.push_back(mk_exp(1'b0, 128'h5A, 1'b0, 1'b0));
      n_strobe = 0;
      send_req(0, 40'h0E, 1'b1);
      wait_drain("no_resp");
      check("no_resp_strobes", n_strobe, 1);
      check("no_resp_flag", seen_nr, 1);

      // hung phy: watchdog abort
      never_ack = 1'b1;
      exp_q.push_back(mk_exp(1'b1, 128'h0, 1'b0, 1'b1));
      send_req(1, 40'h0F, 1'b0);
      lat = 0;
      while (lat < 40) begin
         @(negedge sd_clock);
         if (phy_idle_in) break;
         lat++;
      end
      check("wdog_send_cycles", lat, 16);
      check("abort_strobe_low", phy_strobe_in, 0);
      hi = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge sd_clock);
         if (!phy_idle_in) break;
         hi++;
      end
      check("abort_idle_cycles", hi, 2);
      wait_drain("abort");
      never_ack = 1'b0;

      // reset while waiting for the response
      resp_delay = 6;
      res_q.push_back(mk_res(1'b0, 128'hDEAD));
      send_req(0, 40'h10, 1'b0);
      lat = 0;
      while (lat < 30) begin
         @(negedge sd_clock);
         if (busy && !phy_strobe_in) break;
         lat++;
      end
      reset = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_idle_in", phy_idle_in, 1);
      check("midrst_strobe_in", phy_strobe_in, 0);
      check("midrst_ack_in", phy_ack_in, 0);
      check("midrst_rsp_valid", rsp_valid, 0);
      check("midrst_phy_cmd", phy_cmd, 0);
      repeat (2) @(posedge sd_clock);
      #1 reset = 1'b0;
      res_q.delete();
      resp_delay = 2;
      vcount = 0;
      repeat (20) begin
         @(negedge sd_clock);
         if (rsp_valid) vcount++;
      end
      check("midrst_no_rsp", vcount, 0);

      // recovers after reset
      @(posedge sd_clock); #1;
      res_q.push_back(mk_res(1'b0, 128'h1234));
      exp_q.push_back(mk_exp(1'b0, 128'h1234, 1'b0, 1'b0));
      send_req(0, 40'h11, 1'b0);
      wait_drain("recover");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
